// File: rtl/nbcac_pkg.sv
// -----------------------------------------------------------------------------
// nbcac_pkg
// Shared definitions for the NBCAC (no-boundary crosstalk avoidance code)
// receive path.
//   nbcac_weight(k)   : numeric weight of codeword wire k (1, 2, 3, 5, 8, ...)
//   nbcac_cw_len(dw)  : number of wires needed to carry dw data bits
//   PIPE_OUT_ONLY     : one register stage (decode, then register)
//   PIPE_IN_OUT       : two register stages (register codeword, decode, register)
// -----------------------------------------------------------------------------
package nbcac_pkg;

   localparam int unsigned PIPE_OUT_ONLY = 1;
   localparam int unsigned PIPE_IN_OUT   = 2;

   // Wire k carries Fibonacci weight F(k+1): 1, 2, 3, 5, 8, ...
   function automatic longint unsigned nbcac_weight(input int unsigned k);
      longint unsigned a;
      longint unsigned b;
      longint unsigned t;
      a = 64'd1;
      b = 64'd2;
      for (int unsigned i = 1; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // n wires with the alternating forbidden-pair rule give F(n+2) codewords,
   // i.e. nbcac_weight(n+1); pick the smallest n that covers 2**dw values.
   function automatic int unsigned nbcac_cw_len(input int unsigned dw);
      int unsigned n;
      n = 1;
      for (int unsigned i = 0; i < 90; i++) begin
         if (nbcac_weight(n + 1) < (64'd1 << dw)) begin
            n = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/nbcac_decoder_core.sv
// -----------------------------------------------------------------------------
// nbcac_decoder_core
// Purely combinational NBCAC codeword -> data decoder.
//   d [CW:1]   : codeword, bit 1 = wire 1
//   v [DW-1:0] : decoded data
// Even wires carry the Fibonacci digit directly, odd wires carry it inverted;
// this keeps every adjacent wire pair free of one of the 01/10 patterns, so
// two legal codewords never switch neighbouring wires in opposite directions.
// -----------------------------------------------------------------------------
module nbcac_decoder_core
   import nbcac_pkg::*;
#(
   parameter int unsigned DW = 21,
   parameter int unsigned CW = 30
) (
   output logic [DW-1:0] v,
   input  logic [CW:1]   d
);

   always_comb begin : p_decode
      logic digit;
      v = '0;
      for (int unsigned i = 1; i <= CW; i++) begin
         digit = ((i % 2) == 1) ? ~d[i] : d[i];
         if (digit) begin
            v = v + DW'(nbcac_weight(i));
         end
      end
   end

endmodule

// File: rtl/nbcac_stream_decoder.sv
// -----------------------------------------------------------------------------
// nbcac_stream_decoder
// Streaming NBCAC decoder with valid/ready handshake, adjacent-wire crosstalk
// check against the previously accepted codeword and a saturating error count.
//   clock       : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   code_valid  : codeword present on codein
//   code_ready  : codeword can be accepted this cycle
//   codein      : [CW:1] codeword, bit 1 = wire 1
//   data_valid  : dataout / xt_err valid
//   data_ready  : downstream takes dataout this cycle
//   dataout     : [DW-1:0] decoded data (holds while data_valid = 0)
//   xt_err      : crosstalk violation flag travelling with the codeword
//   err_clr     : synchronous clear of err_cnt
//   err_cnt     : [ERRCNT_W-1:0] saturating count of violating accepts
// -----------------------------------------------------------------------------
module nbcac_stream_decoder
   import nbcac_pkg::*;
#(
   parameter int unsigned DW       = 21,
   parameter int unsigned CW       = 30,
   parameter int unsigned PIPE     = 1,
   parameter int unsigned ERRCNT_W = 16
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                code_valid,
   output logic                code_ready,
   input  logic [CW:1]         codein,
   output logic                data_valid,
   input  logic                data_ready,
   output logic [DW-1:0]       dataout,
   output logic                xt_err,
   input  logic                err_clr,
   output logic [ERRCNT_W-1:0] err_cnt
);

   if (CW != nbcac_cw_len(DW)) begin : g_bad_cw
      $error("nbcac_stream_decoder: CW does not match nbcac_cw_len(DW)");
   end
   if ((PIPE != PIPE_OUT_ONLY) && (PIPE != PIPE_IN_OUT)) begin : g_bad_pipe
      $error("nbcac_stream_decoder: PIPE must be 1 or 2");
   end

   logic          ready_q;
   logic          stall;
   logic          accept;
   logic          viol;
   logic [CW:1]   prev_q;
   logic [CW:1]   rise;
   logic [CW:1]   fall;
   logic [CW:1]   dec_in;
   logic [DW-1:0] dec_out;

   // ready_q keeps code_ready low while in reset without adding any input path.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= 1'b1;
   end

   assign stall      = data_valid & ~data_ready;
   assign code_ready = ready_q & ~stall;
   assign accept     = code_valid & code_ready;

   always_comb begin
      rise = ~prev_q & codein;
      fall = prev_q & ~codein;
      viol = |((rise[CW-1:1] & fall[CW:2]) | (fall[CW-1:1] & rise[CW:2]));
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)      prev_q <= '0;
      else if (accept) prev_q <= codein;
   end

   // err_clr wins over the count, but a violating accept in the same cycle
   // is still recorded as the first error after the clear.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (accept && viol) begin
         if (err_clr)        err_cnt <= ERRCNT_W'(1);
         else if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
         err_cnt <= '0;
      end
   end

   nbcac_decoder_core #(
      .DW (DW),
      .CW (CW)
   ) u_core (
      .v (dec_out),
      .d (dec_in)
   );

   if (PIPE == PIPE_IN_OUT) begin : g_pipe2
      logic        s1_valid;
      logic [CW:1] s1_code;
      logic        s1_xt;

      assign dec_in = s1_code;

      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_code    <= '0;
            s1_xt      <= 1'b0;
            data_valid <= 1'b0;
            dataout    <= '0;
            xt_err     <= 1'b0;
         end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
               s1_code <= codein;
               s1_xt   <= viol;
            end
            data_valid <= s1_valid;
            if (s1_valid) begin
               dataout <= dec_out;
               xt_err  <= s1_xt;
            end
         end
      end
   end else begin : g_pipe1
      assign dec_in = codein;

      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            data_valid <= 1'b0;
            dataout    <= '0;
            xt_err     <= 1'b0;
         end else if (!stall) begin
            data_valid <= accept;
            if (accept) begin
               dataout <= dec_out;
               xt_err  <= viol;
            end
         end
      end
   end

endmodule

// File: tb/tb_nbcac_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_nbcac_stream_decoder
// Directed bench for nbcac_stream_decoder. Two instances share clock/reset:
//   dut_a : DW=21, CW=30, PIPE=1, ERRCNT_W=16
//   dut_b : DW=8,  CW=12, PIPE=2, ERRCNT_W=2
// Inputs change on the falling edge; outputs are sampled shortly after it.
// -----------------------------------------------------------------------------
module tb_nbcac_stream_decoder;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   logic        a_code_valid, a_code_ready, a_data_valid, a_data_ready;
   logic        a_xt_err, a_err_clr;
   logic [30:1] a_codein;
   logic [20:0] a_dataout;
   logic [15:0] a_err_cnt;

   logic        b_code_valid, b_code_ready, b_data_valid, b_data_ready;
   logic        b_xt_err, b_err_clr;
   logic [12:1] b_codein;
   logic [7:0]  b_dataout;
   logic [1:0]  b_err_cnt;

   logic        s_cr, s_dv, s_xt;
   logic [20:0] s_dout;
   logic [15:0] s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   nbcac_stream_decoder #(.DW(21), .CW(30), .PIPE(1), .ERRCNT_W(16)) dut_a (
      .clock(clock), .rst_n(rst_n),
      .code_valid(a_code_valid), .code_ready(a_code_ready), .codein(a_codein),
      .data_valid(a_data_valid), .data_ready(a_data_ready), .dataout(a_dataout),
      .xt_err(a_xt_err), .err_clr(a_err_clr), .err_cnt(a_err_cnt));

   nbcac_stream_decoder #(.DW(8), .CW(12), .PIPE(2), .ERRCNT_W(2)) dut_b (
      .clock(clock), .rst_n(rst_n),
      .code_valid(b_code_valid), .code_ready(b_code_ready), .codein(b_codein),
      .data_valid(b_data_valid), .data_ready(b_data_ready), .dataout(b_dataout),
      .xt_err(b_xt_err), .err_clr(b_err_clr), .err_cnt(b_err_cnt));

   // Greedy Zeckendorf encoder; odd wires are sent inverted.
   function automatic logic [29:0] enc(input int unsigned val, input int unsigned n);
      longint unsigned w[1:30];
      longint unsigned r;
      logic [29:0]     c;
      logic            z;
      w[1] = 1;
      w[2] = 2;
      for (int k = 3; k <= 30; k++) w[k] = w[k-1] + w[k-2];
      r = val;
      c = '0;
      for (int k = int'(n); k >= 1; k--) begin
         z = (r >= w[k]);
         if (z) r = r - w[k];
         c[k-1] = ((k % 2) == 1) ? ~z : z;
      end
      return c;
   endfunction

   task automatic drive_idle();
      a_code_valid = 1'b0; a_codein = '0; a_data_ready = 1'b1; a_err_clr = 1'b0;
      b_code_valid = 1'b0; b_codein = '0; b_data_ready = 1'b1; b_err_clr = 1'b0;
   endtask

   task automatic drive(input bit use_b, input logic v, input logic [29:0] code,
                        input logic rdy, input logic clr);
      if (use_b) begin
         b_code_valid = v; b_codein = code[11:0]; b_data_ready = rdy; b_err_clr = clr;
      end else begin
         a_code_valid = v; a_codein = code; a_data_ready = rdy; a_err_clr = clr;
      end
   endtask

   task automatic sample(input bit use_b);
      if (use_b) begin
         s_cr = b_code_ready; s_dv = b_data_valid; s_xt = b_xt_err;
         s_dout = {13'b0, b_dataout}; s_cnt = {14'b0, b_err_cnt};
      end else begin
         s_cr = a_code_ready; s_dv = a_data_valid; s_xt = a_xt_err;
         s_dout = a_dataout; s_cnt = a_err_cnt;
      end
   endtask

   task automatic apply_reset();
      @(negedge clock);
      drive_idle();
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      drive_idle();
      #1;
      for (int u = 0; u < 2; u++) begin
         sample(u == 1);
         n_checks++; if (s_cr !== 1'b0) begin n_fail++; $display("FAIL rst_cr[%0d]: got %0b want 0", u, s_cr); end
         n_checks++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL rst_dv[%0d]: got %0b want 0", u, s_dv); end
         n_checks++; if (s_dout !== 21'd0) begin n_fail++; $display("FAIL rst_dout[%0d]: got %0d want 0", u, s_dout); end
         n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL rst_xt[%0d]: got %0b want 0", u, s_xt); end
         n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt[%0d]: got %0d want 0", u, s_cnt); end
      end
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      #1;
      for (int u = 0; u < 2; u++) begin
         sample(u == 1);
         n_checks++; if (s_cr !== 1'b1) begin n_fail++; $display("FAIL post_rst_cr[%0d]: got %0b want 1", u, s_cr); end
         n_checks++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL post_rst_dv[%0d]: got %0b want 0", u, s_dv); end
      end
   endtask

   task automatic test_stream(input bit use_b, input int unsigned nwords,
                              input int unsigned pipe, input int unsigned dw,
                              input int unsigned cw);
      int unsigned q_val[$];
      int          q_acc[$];
      int unsigned cur_val, exp_val, idx;
      int          cyc, exp_acc, limit;
      logic        v;
      apply_reset();
      idx = 0;
      cyc = 0;
      limit = int'(nwords) * 4 + 20;
      cur_val = $urandom_range(0, (1 << dw) - 1);
      while ((idx < nwords || q_val.size() > 0) && cyc < limit) begin
         @(negedge clock);
         v = (idx < nwords) && ($urandom_range(0, 4) != 0);
         drive(use_b, v, enc(cur_val, cw), 1'b1, 1'b0);
         #1;
         sample(use_b);
         n_checks++; if (s_cr !== 1'b1) begin n_fail++; $display("FAIL stream_cr: got %0b want 1 at cycle %0d", s_cr, cyc); end
         if (s_dv === 1'b1) begin
            n_checks++;
            if (q_val.size() == 0) begin
               n_fail++; $display("FAIL stream_extra: got data_valid=1 want 0 at cycle %0d", cyc);
            end else begin
               exp_val = q_val.pop_front();
               exp_acc = q_acc.pop_front();
               if (s_dout !== 21'(exp_val)) begin n_fail++; $display("FAIL stream_dout: got %0d want %0d", s_dout, exp_val); end
               n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL stream_xt: got %0b want 0", s_xt); end
               n_checks++; if (cyc - exp_acc != int'(pipe)) begin n_fail++; $display("FAIL stream_latency: got %0d want %0d", cyc - exp_acc, pipe); end
            end
         end else if (q_val.size() > 0) begin
            n_checks++;
            if (cyc >= q_acc[0] + int'(pipe)) begin n_fail++; $display("FAIL stream_missing: got data_valid=0 want 1 at cycle %0d", cyc); end
         end
         if (v) begin
            q_val.push_back(cur_val);
            q_acc.push_back(cyc);
            idx++;
            cur_val = $urandom_range(0, (1 << dw) - 1);
         end
         cyc++;
      end
      n_checks++;
      if (idx != nwords || q_val.size() != 0) begin
         n_fail++; $display("FAIL stream_timeout: got %0d sent %0d pending want %0d sent 0 pending", idx, q_val.size(), nwords);
      end
      drive(use_b, 1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_crosstalk();
      apply_reset();
      @(negedge clock);
      drive(0, 1'b1, 30'h1, 1'b1, 1'b0);
      @(negedge clock);
      drive(0, 1'b1, 30'h2, 1'b1, 1'b0);
      #1; sample(0);
      n_checks++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL xt1_dv: got %0b want 1", s_dv); end
      n_checks++; if (s_dout !== 21'd1346267) begin n_fail++; $display("FAIL xt1_dout: got %0d want 1346267", s_dout); end
      n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL xt1_flag: got %0b want 0", s_xt); end
      n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL xt1_cnt: got %0d want 0", s_cnt); end
      @(negedge clock);
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      #1; sample(0);
      n_checks++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL xt2_dv: got %0b want 1", s_dv); end
      n_checks++; if (s_dout !== 21'd1346270) begin n_fail++; $display("FAIL xt2_dout: got %0d want 1346270", s_dout); end
      n_checks++; if (s_xt !== 1'b1) begin n_fail++; $display("FAIL xt2_flag: got %0b want 1", s_xt); end
      n_checks++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL xt2_cnt: got %0d want 1", s_cnt); end
      @(negedge clock);
      #1; sample(0);
      n_checks++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL xt3_dv: got %0b want 0", s_dv); end
      n_checks++; if (s_dout !== 21'd1346270) begin n_fail++; $display("FAIL xt3_hold: got %0d want 1346270", s_dout); end
      n_checks++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL xt3_cnt: got %0d want 1", s_cnt); end
   endtask

   task automatic test_backpressure();
      int unsigned bp_val[3];
      int unsigned idx, exp_w;
      logic        exp_cr, exp_dv;
      bp_val[0] = 32'h0ABCDE;
      bp_val[1] = 32'h012345;
      bp_val[2] = 32'h1FFFFF;
      apply_reset();
      idx = 0;
      for (int cyc = 0; cyc <= 8; cyc++) begin
         @(negedge clock);
         drive(0, idx < 3, enc(bp_val[(idx < 3) ? idx : 2], 30), cyc >= 5, 1'b0);
         #1; sample(0);
         exp_cr = !(cyc >= 1 && cyc <= 4);
         exp_dv = (cyc >= 1 && cyc <= 7);
         exp_w  = (cyc <= 5) ? 0 : cyc - 5;
         n_checks++; if (s_cr !== exp_cr) begin n_fail++; $display("FAIL bp_cr[%0d]: got %0b want %0b", cyc, s_cr, exp_cr); end
         n_checks++; if (s_dv !== exp_dv) begin n_fail++; $display("FAIL bp_dv[%0d]: got %0b want %0b", cyc, s_dv, exp_dv); end
         if (exp_dv) begin
            n_checks++; if (s_dout !== 21'(bp_val[exp_w])) begin n_fail++; $display("FAIL bp_dout[%0d]: got %0d want %0d", cyc, s_dout, bp_val[exp_w]); end
            n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL bp_xt[%0d]: got %0b want 0", cyc, s_xt); end
         end else if (cyc == 8) begin
            n_checks++; if (s_dout !== 21'(bp_val[2])) begin n_fail++; $display("FAIL bp_hold: got %0d want %0d", s_dout, bp_val[2]); end
         end
         if (exp_cr && idx < 3) idx++;
      end
      drive(0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_err_sat();
      logic [29:0] codes[7];
      int unsigned exp_cnt[7];
      codes   = '{30'h1, 30'h2, 30'h1, 30'h2, 30'h1, 30'h2, 30'h1};
      exp_cnt = '{0, 1, 2, 3, 3, 3, 1};
      apply_reset();
      for (int j = 0; j <= 8; j++) begin
         @(negedge clock);
         #1; sample(1);
         if (j > 0 && j <= 7) begin
            n_checks++; if (s_cnt !== 16'(exp_cnt[j-1])) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", j - 1, s_cnt, exp_cnt[j-1]); end
         end else if (j == 8) begin
            n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", s_cnt); end
         end
         if (j < 7)       drive(1, 1'b1, codes[j], 1'b1, j == 6);
         else if (j == 7) drive(1, 1'b0, '0, 1'b1, 1'b1);
         else             drive(1, 1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_midstream();
      logic [29:0] codes[3];
      codes = '{30'h1, 30'h2, 30'h1};
      apply_reset();
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         drive(1, 1'b1, codes[j], 1'b1, 1'b0);
      end
      @(negedge clock);
      drive(1, 1'b0, '0, 1'b1, 1'b0);
      #1; sample(1);
      n_checks++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL mid_pre_dv: got %0b want 1", s_dv); end
      n_checks++; if (s_dout !== 21'd234) begin n_fail++; $display("FAIL mid_pre_dout: got %0d want 234", s_dout); end
      n_checks++; if (s_xt !== 1'b1) begin n_fail++; $display("FAIL mid_pre_xt: got %0b want 1", s_xt); end
      n_checks++; if (s_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d want 2", s_cnt); end
      rst_n = 1'b0;
      #1; sample(1);
      n_checks++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dv: got %0b want 0", s_dv); end
      n_checks++; if (s_dout !== 21'd0) begin n_fail++; $display("FAIL mid_rst_dout: got %0d want 0", s_dout); end
      n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_xt: got %0b want 0", s_xt); end
      n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", s_cnt); end
      n_checks++; if (s_cr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cr: got %0b want 0", s_cr); end
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      drive(1, 1'b1, 30'h2, 1'b1, 1'b0);
      #1; sample(1);
      n_checks++; if (s_cr !== 1'b1) begin n_fail++; $display("FAIL mid_post_cr: got %0b want 1", s_cr); end
      @(negedge clock);
      drive(1, 1'b0, '0, 1'b1, 1'b0);
      #1; sample(1);
      n_checks++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL mid_post_dv_early: got %0b want 0", s_dv); end
      @(negedge clock);
      #1; sample(1);
      n_checks++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL mid_post_dv: got %0b want 1", s_dv); end
      n_checks++; if (s_dout !== 21'd234) begin n_fail++; $display("FAIL mid_post_dout: got %0d want 234", s_dout); end
      n_checks++; if (s_xt !== 1'b0) begin n_fail++; $display("FAIL mid_post_xt: got %0b want 0", s_xt); end
      n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_post_cnt: got %0d want 0", s_cnt); end
   endtask

   initial begin
      test_reset();
      test_stream(1'b0, 100, 1, 21, 30);
      test_crosstalk();
      test_backpressure();
      test_stream(1'b1, 60, 2, 8, 12);
      test_err_sat();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nbcac_stream_decoder.md
Name: nbcac_stream_decoder

Overview:
- Parametrised, streaming successor to the fixed 30-to-21 NBCAC decoder wrapper.
- Decodes CW-bit NBCAC codewords to DW-bit data through a valid/ready pipeline of 1 or 2 register stages.
- Checks each accepted codeword against the previous one for forbidden adjacent-wire opposite transitions (crosstalk class violation), with a saturating error counter.
- Sits at the receive end of an on-chip CAC-coded bus, ahead of the consumer logic.

Parameters:
- DW, 21, decoded data width.
- CW, 30, codeword width; must equal nbcac_pkg::nbcac_cw_len(DW), elaboration error otherwise.
- PIPE, 1, register stages from accept to output (1 or 2; other values are an elaboration error).
- ERRCNT_W, 16, width of the crosstalk error counter.

Ports:
- clock  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- code_valid  in  1  codeword present on codein.
- code_ready  out  1  block can accept a codeword this cycle.
- codein  in  CW  codeword, bit index [CW:1], bit 1 = wire 1.
- data_valid  out  1  dataout/xt_err valid.
- data_ready  in  1  downstream accepts dataout this cycle.
- dataout  out  DW  decoded data.
- xt_err  out  1  crosstalk violation flag for the codeword that produced dataout.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  ERRCNT_W  saturating count of violating codewords accepted.

Behaviour:
- Reset (async, rst_n low): all outputs 0; prev-codeword register 0; pipeline valid bits 0. code_ready = 1 from the first cycle after reset.
- Accept: code_valid & code_ready. Deliver: data_valid & data_ready.
- Stall = data_valid & ~data_ready.
- code_ready = ~stall. Combinational from data_ready; no other combinational in-to-out paths.
- Pipeline movement: when not stalled, every stage advances; the stage-1 valid bit takes code_valid. When stalled, all stages hold, including data and xt_err.
- Latency: an accepted codeword appears on the outputs PIPE cycles later. Throughput is one codeword per cycle under continuous data_ready.
- Decode: dataout = nbcac_decoder_core(codein), combinational.
  - PIPE=1: registered at the output.
  - PIPE=2: codein is registered first, then decoded into the output register.
- dataout holds its last value when data_valid = 0.
- Crosstalk check, evaluated on accept against prev (the last accepted codeword; 0 after reset):
  - rise[i] = ~prev[i] & codein[i]
  - fall[i] = prev[i] & ~codein[i]
  - violation = OR over i=1..CW-1 of (rise[i] & fall[i+1]) | (fall[i] & rise[i+1])
  - prev <= codein on accept only.
  - The flag travels with its codeword through the pipeline.
- Error counter:
  - Increments on accept of a violating codeword; saturates at all-ones.
  - err_clr forces 0, except that err_clr together with a violating accept yields 1.
- Rejected inputs (code_valid while code_ready = 0) have no effect on prev, the counter or the pipeline.
- Reset mid-stream: in-flight codewords are dropped and prev returns to 0.

Decomposition:
- Package nbcac_pkg:
  - function nbcac_cw_len(DW), the NBCAC code length for DW data bits (21 -> 30).
  - localparams for the supported PIPE values.
- Sub-module nbcac_decoder_core #(DW, CW):
  - purely combinational; ports v[DW-1:0] and d[CW:1].
  - At DW=21 its mapping must be bit-identical to nbcac_21di_decoder_core.
- Crosstalk check and the pipeline stay in the top module.

Test Plan:
- Reset, then stream 100 random valid NBCAC codewords (from the encoder model) with data_ready = 1 -> in-order dataout matches the golden decoder; latency is exactly PIPE cycles; xt_err = 0 when the sequence is legal.
- codein = 30'h1 then 30'h2 (wire 1 falls while wire 2 rises) -> xt_err = 0 for the first codeword and 1 for the second; err_cnt = 1.
- Hold data_ready = 0 for 5 cycles with 3 codewords offered -> code_ready = 0 once data_valid is asserted; the output holds stable; after release, all words arrive in order with no loss or duplication.
- ERRCNT_W = 2, 5 violating codewords -> err_cnt reads 1, 2, 3, 3, 3. Then err_clr asserted in the same cycle as a violating accept -> err_cnt = 1.
- Assert rst_n low mid-stream with PIPE = 2 -> data_valid, xt_err, dataout and err_cnt are 0 immediately. The next codeword 30'h2 is checked against prev = 0 -> xt_err = 0.
- Parameter sweep with DW = 8 and DW = 21, PIPE = 1 and 2 -> the same checks pass; CW mismatched with nbcac_cw_len(DW) -> elaboration error.
